// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam int   PAR_MAX_W = 9;

    // Zero-extended words keep the XOR unchanged, so one width serves all frame sizes.
    function automatic logic parity_of(input logic [PAR_MAX_W-1:0] word, input logic par_typ);
        return (^word) ^ (par_typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Word handshake plus per-frame configuration offered to the UART transmitter.
interface uart_tx_cfg_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  DATA_READY;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [PRESCALE_W-1:0] PRESCALE;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, PRESCALE,
        input  DATA_READY
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2, PRESCALE,
        output DATA_READY
    );
endinterface

// File: rtl/parity_calc.sv
// Combinational parity of a data word, even or odd as selected.
module parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);
    logic [PAR_MAX_W-1:0] data_ext_s;

    // Extend to the helper width and evaluate parity.
    always_comb begin
        data_ext_s                 = '0;
        data_ext_s[DATA_WIDTH-1:0] = data;
        par_bit                    = parity_of(data_ext_s, par_typ);
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a one-entry holding register and per-frame captured
// parity/stop/prescale settings; back-to-back frames leave no idle gap.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_cfg_if.slave  bus,
    output logic          TX_OUT,
    output logic          BUSY
);
    localparam int                  BCW       = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0]      LAST_DATA = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0]      BIT_ONE   = BCW'(1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

    logic [DATA_WIDTH-1:0] hold_data_r;
    logic                  hold_full_r;
    logic                  hold_par_en_r;
    logic                  hold_par_typ_r;
    logic                  hold_stop2_r;
    logic [PRESCALE_W-1:0] hold_pre_r;
    logic                  ready_r;

    uart_state_e           state_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  frm_par_en_r;
    logic                  frm_par_bit_r;
    logic                  frm_stop2_r;
    logic [PRESCALE_W-1:0] frm_pre_r;
    logic [PRESCALE_W-1:0] pre_cnt_r;
    logic [BCW-1:0]        bit_cnt_r;
    logic                  tx_r;
    logic                  busy_r;

    logic                  accept_s;
    logic                  take_s;
    logic                  bit_done_s;
    logic                  last_stop_s;
    logic                  hold_par_bit_s;

    parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data    (hold_data_r),
        .par_typ (hold_par_typ_r),
        .par_bit (hold_par_bit_s)
    );

    // Handshake, bit timing and frame-start decisions.
    always_comb begin
        accept_s = bus.DATA_VALID & ready_r;
        if (frm_pre_r <= PRE_ONE) begin
            bit_done_s = 1'b1;
        end else begin
            bit_done_s = (pre_cnt_r == (frm_pre_r - PRE_ONE));
        end
        last_stop_s = (state_r == ST_STOP) & bit_done_s &
                      (bit_cnt_r == {{(BCW-1){1'b0}}, frm_stop2_r});
        take_s      = hold_full_r & ((state_r == ST_IDLE) | last_stop_s);
    end

    // Holding register: a transfer and an accept can never coincide because
    // ready is low whenever the register is full.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            hold_full_r    <= 1'b0;
            ready_r        <= 1'b1;
            hold_data_r    <= '0;
            hold_par_en_r  <= 1'b0;
            hold_par_typ_r <= PAR_EVEN;
            hold_stop2_r   <= 1'b0;
            hold_pre_r     <= '0;
        end else if (take_s) begin
            hold_full_r <= 1'b0;
            ready_r     <= 1'b1;
        end else if (accept_s) begin
            hold_full_r    <= 1'b1;
            ready_r        <= 1'b0;
            hold_data_r    <= bus.P_DATA;
            hold_par_en_r  <= bus.PAR_EN;
            hold_par_typ_r <= bus.PAR_TYP;
            hold_stop2_r   <= bus.STOP2;
            hold_pre_r     <= bus.PRESCALE;
        end
    end

    // Frame FSM with registered line and busy outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r       <= ST_IDLE;
            tx_r          <= 1'b1;
            busy_r        <= 1'b0;
            shift_r       <= '0;
            frm_par_en_r  <= 1'b0;
            frm_par_bit_r <= 1'b0;
            frm_stop2_r   <= 1'b0;
            frm_pre_r     <= '0;
            pre_cnt_r     <= '0;
            bit_cnt_r     <= '0;
        end else if (take_s) begin
            state_r       <= ST_START;
            tx_r          <= 1'b0;
            busy_r        <= 1'b1;
            shift_r       <= hold_data_r;
            frm_par_en_r  <= hold_par_en_r;
            frm_par_bit_r <= hold_par_bit_s;
            frm_stop2_r   <= hold_stop2_r;
            frm_pre_r     <= hold_pre_r;
            pre_cnt_r     <= '0;
            bit_cnt_r     <= '0;
        end else if (state_r == ST_IDLE) begin
            tx_r      <= 1'b1;
            busy_r    <= 1'b0;
            pre_cnt_r <= '0;
            bit_cnt_r <= '0;
        end else if (!bit_done_s) begin
            pre_cnt_r <= pre_cnt_r + PRE_ONE;
        end else begin
            pre_cnt_r <= '0;
            case (state_r)
                ST_START: begin
                    state_r   <= ST_DATA;
                    tx_r      <= shift_r[0];
                    bit_cnt_r <= '0;
                end
                ST_DATA: begin
                    if (bit_cnt_r == LAST_DATA) begin
                        bit_cnt_r <= '0;
                        if (frm_par_en_r) begin
                            state_r <= ST_PARITY;
                            tx_r    <= frm_par_bit_r;
                        end else begin
                            state_r <= ST_STOP;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        shift_r   <= shift_r >> 1;
                        tx_r      <= shift_r[1];
                        bit_cnt_r <= bit_cnt_r + BIT_ONE;
                    end
                end
                ST_PARITY: begin
                    state_r   <= ST_STOP;
                    tx_r      <= 1'b1;
                    bit_cnt_r <= '0;
                end
                ST_STOP: begin
                    tx_r <= 1'b1;
                    if (last_stop_s) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        bit_cnt_r <= '0;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BIT_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    tx_r      <= 1'b1;
                    busy_r    <= 1'b0;
                    bit_cnt_r <= '0;
                end
            endcase
        end
    end

    assign TX_OUT         = tx_r;
    assign BUSY           = busy_r;
    assign bus.DATA_READY = ready_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed, table-driven bench for uart_tx_cfg (8-bit and 7-bit builds).
module tb_uart_tx_cfg;

    logic clk = 1'b0;
    logic rst_n;
    logic tx8, busy8, tx7, busy7;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus8 ();
    uart_tx_cfg_if #(.DATA_WIDTH(7), .PRESCALE_W(6)) bus7 ();

    uart_tx_cfg #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut8 (
        .CLK(clk), .RST(rst_n), .bus(bus8), .TX_OUT(tx8), .BUSY(busy8)
    );
    uart_tx_cfg #(.DATA_WIDTH(7), .PRESCALE_W(6)) dut7 (
        .CLK(clk), .RST(rst_n), .bus(bus7), .TX_OUT(tx7), .BUSY(busy7)
    );

    // Expected line sequence: transmitted bit i is seq[11-i].
    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic        stop2;
        logic [5:0]  pre;
        int          per;
        int          nbits;
        logic [11:0] seq;
        string       name;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input bit sel7);
        return sel7 ? tx7 : tx8;
    endfunction

    function automatic logic get_busy(input bit sel7);
        return sel7 ? busy7 : busy8;
    endfunction

    function automatic logic get_ready(input bit sel7);
        return sel7 ? bus7.DATA_READY : bus8.DATA_READY;
    endfunction

    // Offer a word at a negedge; returns at the second negedge after acceptance.
    task automatic send(input bit sel7, input logic [7:0] data, input logic pe, input logic pt,
                        input logic s2, input logic [5:0] pre, input bit chk_lat, input string name);
        int waited;
        waited = 0;
        while (get_ready(sel7) !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s ready_timeout: ready still %b after %0d cycles", name, get_ready(sel7), waited);
        end else begin
            if (sel7) begin
                bus7.P_DATA = data[6:0]; bus7.PAR_EN = pe; bus7.PAR_TYP = pt;
                bus7.STOP2 = s2; bus7.PRESCALE = pre; bus7.DATA_VALID = 1'b1;
            end else begin
                bus8.P_DATA = data; bus8.PAR_EN = pe; bus8.PAR_TYP = pt;
                bus8.STOP2 = s2; bus8.PRESCALE = pre; bus8.DATA_VALID = 1'b1;
            end
            @(negedge clk);
            bus7.DATA_VALID = 1'b0;
            bus8.DATA_VALID = 1'b0;
            if (chk_lat) begin
                check({name, " tx_before_start"}, 32'(get_tx(sel7)), 32'd1);
                check({name, " ready_when_full"}, 32'(get_ready(sel7)), 32'd0);
            end
            @(negedge clk);
        end
    endtask

    // Walk one frame cycle by cycle from its first START cycle.
    task automatic check_frame(input bit sel7, input logic [11:0] seq, input int nbits,
                               input int per, input string name, output int busy_cnt);
        int   bad;
        logic expb;
        busy_cnt = 0;
        for (int i = 0; i < nbits; i++) begin
            bad  = 0;
            expb = seq[11-i];
            for (int c = 0; c < per; c++) begin
                if (get_tx(sel7) !== expb || get_busy(sel7) !== 1'b1) bad++;
                if (get_busy(sel7) === 1'b1) busy_cnt++;
                if (i == 0 && c == 0)
                    check({name, " ready_in_start"}, 32'(get_ready(sel7)), 32'd1);
                @(negedge clk);
            end
            check($sformatf("%s bit%0d_bad_cycles", name, i), 32'(bad), 32'd0);
        end
    endtask

    task automatic check_idle(input bit sel7, input string name);
        check({name, " idle_tx"}, 32'(get_tx(sel7)), 32'd1);
        check({name, " idle_busy"}, 32'(get_busy(sel7)), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, bc2, nonidle;

        vecs[0] = '{8'hCC, 1'b1, 1'b0, 1'b0, 6'd32, 32, 11, 12'b000110011010, "cc_even_p32"};
        vecs[1] = '{8'h04, 1'b0, 1'b0, 1'b1, 6'd4,  4,  11, 12'b000100000110, "x04_nopar_stop2"};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 6'd3,  3,  11, 12'b010100101110, "a5_odd_p3"};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, 6'd1,  1,  12, 12'b011111111011, "ff_even_stop2_p1"};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0, 6'd0,  1,  11, 12'b010000000010, "x01_odd_p0"};

        rst_n = 1'b0;
        bus8.P_DATA = '0; bus8.DATA_VALID = 1'b0; bus8.PAR_EN = 1'b0;
        bus8.PAR_TYP = 1'b0; bus8.STOP2 = 1'b0; bus8.PRESCALE = '0;
        bus7.P_DATA = '0; bus7.DATA_VALID = 1'b0; bus7.PAR_EN = 1'b0;
        bus7.PAR_TYP = 1'b0; bus7.STOP2 = 1'b0; bus7.PRESCALE = '0;
        repeat (3) @(negedge clk);

        check("reset tx8", 32'(tx8), 32'd1);
        check("reset busy8", 32'(busy8), 32'd0);
        check("reset ready8", 32'(bus8.DATA_READY), 32'd1);
        check("reset tx7", 32'(tx7), 32'd1);
        check("reset busy7", 32'(busy7), 32'd0);
        check("reset ready7", 32'(bus7.DATA_READY), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            send(1'b0, vecs[k].data, vecs[k].par_en, vecs[k].par_typ, vecs[k].stop2,
                 vecs[k].pre, 1'b1, vecs[k].name);
            check_frame(1'b0, vecs[k].seq, vecs[k].nbits, vecs[k].per, vecs[k].name, bc);
            check({vecs[k].name, " busy_cycles"}, 32'(bc), 32'(vecs[k].nbits * vecs[k].per));
            check_idle(1'b0, vecs[k].name);
            repeat (2) @(negedge clk);
        end

        // Back-to-back words, odd parity: the second frame follows with no gap.
        send(1'b0, 8'h05, 1'b1, 1'b1, 1'b0, 6'd2, 1'b1, "b2b_w1");
        fork
            begin
                check_frame(1'b0, 12'b010100000110, 11, 2, "b2b_f1", bc);
                check_frame(1'b0, 12'b011100000010, 11, 2, "b2b_f2", bc2);
            end
            send(1'b0, 8'h07, 1'b1, 1'b1, 1'b0, 6'd2, 1'b0, "b2b_w2");
        join
        check("b2b busy_cycles", 32'(bc + bc2), 32'd44);
        check_idle(1'b0, "b2b");
        repeat (2) @(negedge clk);

        // Configuration changed mid-frame must not touch the frame in flight.
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 6'd32, 1'b1, "pre32");
        fork
            check_frame(1'b0, 12'b000111100100, 10, 32, "pre32_frame", bc);
            begin
                repeat (40) @(negedge clk);
                bus8.PRESCALE = 6'd8;
                bus8.STOP2    = 1'b1;
                bus8.PAR_EN   = 1'b1;
            end
        join
        check("pre32 busy_cycles", 32'(bc), 32'd320);
        check_idle(1'b0, "pre32");
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 6'd8, 1'b1, "pre8");
        check_frame(1'b0, 12'b000111100100, 10, 8, "pre8_frame", bc);
        check("pre8 busy_cycles", 32'(bc), 32'd80);
        check_idle(1'b0, "pre8");
        repeat (2) @(negedge clk);

        // Reset in the middle of data bit 3, with a word offered in the reset cycle.
        send(1'b0, 8'hDD, 1'b1, 1'b0, 1'b0, 6'd4, 1'b1, "rst");
        repeat (16) @(negedge clk);
        check("rst busy_before", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        bus8.P_DATA = 8'h0F;
        bus8.DATA_VALID = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        bus8.DATA_VALID = 1'b0;
        check("rst tx_after", 32'(tx8), 32'd1);
        check("rst busy_after", 32'(busy8), 32'd0);
        check("rst ready_after", 32'(bus8.DATA_READY), 32'd1);
        nonidle = 0;
        for (int c = 0; c < 30; c++) begin
            if (tx8 !== 1'b1 || busy8 !== 1'b0 || bus8.DATA_READY !== 1'b1) nonidle++;
            @(negedge clk);
        end
        check("rst residual_cycles", 32'(nonidle), 32'd0);

        // 7-bit build, PRESCALE=0 behaves as one cycle per bit.
        send(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, "w7");
        check_frame(1'b1, 12'b010101010100, 10, 1, "w7_frame", bc);
        check("w7 busy_cycles", 32'(bc), 32'd10);
        check_idle(1'b1, "w7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
